// File: rtl/pipe_pkg.sv
// Shared pipeline control bundle layout, bit positions and opcodes.
// Pure definitions: no latency, no flow control.
package pipe_pkg;

    localparam int WB_W  = 2;
    localparam int MEM_W = 3;
    localparam int EX_W  = 4;

    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    localparam int MEM_BRANCH = 2;
    localparam int MEM_READ   = 1;
    localparam int MEM_WRITE  = 0;

    localparam int EX_REGDST   = 3;
    localparam int EX_ALUOP_HI = 2;
    localparam int EX_ALUOP_LO = 1;
    localparam int EX_ALUSRC   = 0;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;

    typedef struct packed {
        logic [WB_W-1:0]  wb;
        logic [MEM_W-1:0] mem;
        logic [EX_W-1:0]  ex;
    } ctrl_t;

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detect against the load in EX; purely combinational (0 cycles).
// Stall is suppressed by flush since the ID instruction is being squashed anyway.
module hazard_unit #(
    parameter int REG_W = 5
) (
    input  logic             ex_valid_i,
    input  logic             ex_memread_i,
    input  logic [REG_W-1:0] ex_rt_i,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             flush_i,
    output logic             hazard_o,
    output logic             stall_o
);

    // $0 is hardwired, so a load into it can never create a dependency
    assign hazard_o = ex_valid_i & ex_memread_i & id_valid_i & (ex_rt_i != '0) &
                      ((ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i));
    assign stall_o  = hazard_o & ~flush_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion; 1-cycle ID->EX latency.
// Stall holds PC/IF-ID upstream while a bubble enters EX; flush squashes ID.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WB_W-1:0]   wb_in,
    input  logic [MEM_W-1:0]  mem_in,
    input  logic [EX_W-1:0]   ex_in,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] npc_in,
    input  logic [DATA_W-1:0] rd1_in,
    input  logic [DATA_W-1:0] rd2_in,
    input  logic [DATA_W-1:0] sext_in,
    input  logic [REG_W-1:0]  rs_in,
    input  logic [REG_W-1:0]  rt_in,
    input  logic [REG_W-1:0]  rd_in,
    input  logic              flush,
    output logic [WB_W-1:0]   wb_out,
    output logic [MEM_W-1:0]  mem_out,
    output logic [EX_W-1:0]   ex_out,
    output logic [DATA_W-1:0] npc_out,
    output logic [DATA_W-1:0] rd1_out,
    output logic [DATA_W-1:0] rd2_out,
    output logic [DATA_W-1:0] sext_out,
    output logic [REG_W-1:0]  rs_out,
    output logic [REG_W-1:0]  rt_out,
    output logic [REG_W-1:0]  rd_out,
    output logic              ex_valid,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_cnt
);

    ctrl_t             ctrl_q, ctrl_d;
    logic [DATA_W-1:0] npc_q, npc_d, rd1_q, rd1_d, rd2_q, rd2_d, sext_q, sext_d;
    logic [REG_W-1:0]  rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hazard;

    hazard_unit #(.REG_W(REG_W)) u_hazard (
        .ex_valid_i   (valid_q),
        .ex_memread_i (ctrl_q.mem[MEM_READ]),
        .ex_rt_i      (rt_q),
        .id_valid_i   (id_valid),
        .id_rs_i      (rs_in),
        .id_rt_i      (rt_in),
        .flush_i      (flush),
        .hazard_o     (hazard),
        .stall_o      (stall)
    );

    // flush|hazard equals flush|stall: either way a bubble goes into EX
    always_comb begin
        ctrl_d  = '0;
        npc_d   = '0;
        rd1_d   = '0;
        rd2_d   = '0;
        sext_d  = '0;
        rs_d    = '0;
        rt_d    = '0;
        rd_d    = '0;
        valid_d = 1'b0;
        cnt_d   = cnt_q;
        if (flush | hazard) begin
            if (stall && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            npc_d   = npc_in;
            rd1_d   = rd1_in;
            rd2_d   = rd2_in;
            sext_d  = sext_in;
            rs_d    = rs_in;
            rt_d    = rt_in;
            rd_d    = rd_in;
            valid_d = id_valid;
            if (id_valid) begin
                ctrl_d = '{wb: wb_in, mem: mem_in, ex: ex_in};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q  <= '0;
            npc_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            sext_q  <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            npc_q   <= npc_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            sext_q  <= sext_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wb_out    = ctrl_q.wb;
    assign mem_out   = ctrl_q.mem;
    assign ex_out    = ctrl_q.ex;
    assign npc_out   = npc_q;
    assign rd1_out   = rd1_q;
    assign rd2_out   = rd2_q;
    assign sext_out  = sext_q;
    assign rs_out    = rs_q;
    assign rt_out    = rt_q;
    assign rd_out    = rd_q;
    assign ex_valid  = valid_q;
    assign stall_cnt = cnt_q;

endmodule
